// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state type, default
// sizing constants and the product-width helper.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int NREQ_DEF    = 4;
    localparam int W_DEF       = 4;
    localparam int TIMEOUT_DEF = 32;

    // Full product width of a W x W unsigned multiply.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Rotating-priority encoder: the search starts at ptr and wraps, the first
// asserted request wins. Purely combinational.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    // Walk the requesters in priority order starting at ptr; keep the first hit.
    always_comb begin
        int j;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one sequential multiplier among NREQ
// requesters. Each operation runs IDLE -> ISSUE -> WAIT -> RESP.
// Optional WAIT watchdog: define MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ           = NREQ_DEF,
    parameter int W              = W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       a_in,
    input  logic [NREQ*W-1:0]       b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [prod_w(W)-1:0]    rsp_product,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    mul_start,
    output logic [W-1:0]            mul_a,
    output logic [W-1:0]            mul_b,
    input  logic [prod_w(W)-1:0]    mul_product,
    input  logic                    mul_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_vld;
    logic            timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_vld)
    );

    assign win_oh = NREQ'(1) << win;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    assign timeout_hit = (state == WAIT) && !mul_done && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts WAIT cycles and flags the response when it expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            rsp_err <= 1'b0;
        end else if (state == ISSUE) begin
            tcnt    <= '0;
            rsp_err <= 1'b0;
        end else if (state == WAIT) begin
            if (mul_done) begin
                rsp_err <= 1'b0;
            end else if (timeout_hit) begin
                rsp_err <= 1'b1;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; grant is held from ISSUE through RESP.
    always_comb begin
        state_nxt = state;
        gnt       = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (arb_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                mul_start = 1'b1;
                gnt       = win_oh;
                state_nxt = WAIT;
            end
            WAIT: begin
                gnt = win_oh;
                if (mul_done || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                gnt       = win_oh;
                rsp_valid = win_oh;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch at arbitration, result capture in WAIT, pointer advance in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            win         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_product <= '0;
        end else begin
            if (state == IDLE && arb_vld) begin
                win   <= arb_idx;
                mul_a <= a_in[arb_idx*W +: W];
                mul_b <= b_in[arb_idx*W +: W];
            end
            if (state == WAIT && mul_done) begin
                rsp_product <= mul_product;
            end else if (timeout_hit) begin
                rsp_product <= '0;
            end
            if (state == RESP) begin
                ptr <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
            end
        end
    end

    // arb_gnt mirrors arb_idx; only the index is needed here.
    logic unused_gnt;
    assign unused_gnt = ^arb_gnt;

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized self-checking bench for mult_arbiter with a transaction-level
// reference: round-robin winner search, product = A*B, fixed phase timing.
module tb_mult_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_product;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_product;
    logic              mul_done;

    logic [W-1:0] a_v [NREQ];
    logic [W-1:0] b_v [NREQ];

    int n_chk  = 0;
    int n_fail = 0;
    int mptr   = 0;
    int order[$];

    always #5 clk = ~clk;

    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*W +: W] = a_v[i];
            b_in[i*W +: W] = b_v[i];
        end
    end

    mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYCLES(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .a_in        (a_in),
        .b_in        (b_in),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_done    (mul_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first requester at or after p, wrapping.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        req      = '0;
        mul_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
    endtask

    // One complete operation: dly WAIT cycles, optional stale done in IDLE/ISSUE.
    task automatic op(input logic [NREQ-1:0] r, input int dly, input bit stale, input bit hold);
        int             w;
        logic [NREQ-1:0] oh;
        logic [2*W-1:0] exp;
        w   = pick(r, mptr);
        oh  = NREQ'(1) << w;
        exp = (2*W)'(a_v[w]) * (2*W)'(b_v[w]);

        @(negedge clk);
        req         = r;
        mul_done    = stale;
        mul_product = ~exp;
        @(posedge clk); #1;
        chk("issue_start", mul_start, 1);
        chk("issue_gnt", gnt, oh);
        chk("issue_mul_a", mul_a, a_v[w]);
        chk("issue_mul_b", mul_b, b_v[w]);
        chk("issue_busy", busy, 1);

        @(negedge clk);
        mul_done    = stale;
        mul_product = ~exp;
        for (int i = 0; i < NREQ; i++)
            if (!r[i]) begin
                a_v[i] = W'($urandom);
                b_v[i] = W'($urandom);
            end
        @(posedge clk); #1;
        chk("start_pulse", mul_start, 0);
        chk("early_rsp", rsp_valid, 0);

        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            mul_done    = (k == dly - 1);
            mul_product = (k == dly - 1) ? exp : ~exp;
            @(posedge clk); #1;
            if (k < dly - 1) begin
                chk("wait_rsp", rsp_valid, 0);
                chk("wait_gnt", gnt, oh);
                chk("wait_mul_a", mul_a, a_v[w]);
            end
        end

        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_product", rsp_product, exp);
        chk("rsp_err", rsp_err, 0);
        chk("resp_gnt", gnt, oh);
        order.push_back(w);
        mptr = (w + 1) % NREQ;

        @(negedge clk);
        mul_done    = 1'b1;
        mul_product = ~exp;
        if (!hold) req = r & ~oh;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_rsp", rsp_valid, 0);
        chk("idle_gnt", gnt, 0);
    endtask

    // Launch an operation for r, then pull reset while it sits in WAIT.
    task automatic reset_mid_wait(input logic [NREQ-1:0] r);
        @(negedge clk);
        req      = r;
        mul_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mul_done = 1'b1;
            @(posedge clk); #1;
            chk("rst_no_rsp", rsp_valid, 0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        mul_done = 1'b0;
        mptr     = 0;
        @(posedge clk); #1;
        chk("post_rst_no_rsp", rsp_valid, 0);
    endtask

    initial begin
        int exp_order[5];
        int n;
        rst_n       = 1'b0;
        req         = '0;
        mul_done    = 1'b0;
        mul_product = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("reset_gnt", gnt, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_product", rsp_product, 0);
        chk("reset_err", rsp_err, 0);
        chk("reset_busy", busy, 0);
        chk("reset_start", mul_start, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request 10 x 3.
        a_v[0] = 4'd10;
        b_v[0] = 4'd3;
        op(4'b0001, 2, 0, 0);

        // Two simultaneous requests from a fresh pointer.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = W'($urandom);
            b_v[i] = W'($urandom);
        end
        op(4'b0101, 1, 0, 0);
        op(4'b0100, 3, 0, 0);
        chk("simul_first", order[order.size()-2], 0);
        chk("simul_second", order[order.size()-1], 2);

        // Fairness with every requester held high, all-ones operands.
        do_reset();
        order.delete();
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = 4'hF;
            b_v[i] = 4'hF;
        end
        for (int k = 0; k < 5; k++) op(4'b1111, 1 + k % 3, 0, 1);
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) chk("fair_order", order[k], exp_order[k]);
        @(negedge clk);
        req = '0;

        // Stale done in IDLE/ISSUE must not shorten the operation.
        a_v[1] = 4'd7;
        b_v[1] = 4'd9;
        op(4'b0010, 1, 1, 0);
        op(4'b0010, 2, 1, 0);

        // Reset during WAIT, then service of requester 3.
        reset_mid_wait(4'b0100);
        a_v[3] = 4'd12;
        b_v[3] = 4'd11;
        op(4'b1000, 2, 0, 0);

        // Reset with a nonzero pointer; the next arbitration starts from 0.
        op(4'b0010, 1, 0, 0);
        reset_mid_wait(4'b0100);
        op(4'b1001, 1, 0, 0);
        chk("ptr_after_reset", order[order.size()-1], 0);

        // Randomized traffic.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_v[i] = W'($urandom);
                b_v[i] = W'($urandom);
            end
            op(NREQ'($urandom_range(1, 15)), $urandom_range(1, 5), $urandom_range(0, 1) == 1, 0);
        end

`ifdef MULT_ARB_TIMEOUT_EN
        // Watchdog: multiplier never completes.
        do_reset();
        a_v[0] = 4'd5;
        b_v[0] = 4'd7;
        @(negedge clk);
        req      = 4'b0001;
        mul_done = 1'b0;
        @(posedge clk); #1;
        chk("to_start", mul_start, 1);
        n = 0;
        while (rsp_valid == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_cycles", n, 33);
        chk("to_rsp_valid", rsp_valid, 4'b0001);
        chk("to_err", rsp_err, 1);
        chk("to_product", rsp_product, 0);
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        chk("to_idle", busy, 0);
`else
        n = 0;
`endif

        @(negedge clk);
        req = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
